// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the read side of a FIFO with a registered read port
// into a valid/ready stream through a 3-entry skid buffer.
// Optional feature: define FIFO_RD_CNT_EN to add the 16-bit rd_cnt output
// (completed transfer count, wrapping).
module fifo_rd_stream #(
   parameter int WIDTH = 8
) (
   input  logic             rclk,
   input  logic             rrstn,
   input  logic             rempty,
   input  logic [WIDTH-1:0] rdata,
   output logic             rinc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]      rd_cnt
`endif
);

   localparam int BUF_DEPTH = 3;

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [1:0]       level_q;
   logic             inflight;
   logic             xfer;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Pop only while a free slot exists for the word that will arrive next
   // cycle; out_ready is deliberately kept out of this path.
   always_comb begin
      rinc = rrstn && !rempty &&
             (({1'b0, level_q} + {2'b00, inflight}) < 3'(BUF_DEPTH));
      xfer = (level_q != 2'd0) && out_ready;
   end

   // Capture the registered FIFO read data the cycle after each pop.
   always_ff @(posedge rclk or negedge rrstn) begin
      if (!rrstn) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else if (inflight) begin
         mem[wr_ptr] <= rdata;
      end
   end

   // Pointers, occupancy and the in-flight marker.
   always_ff @(posedge rclk or negedge rrstn) begin
      if (!rrstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= rinc;
         if (inflight) wr_ptr <= ptr_next(wr_ptr);
         if (xfer)     rd_ptr <= ptr_next(rd_ptr);
         level_q <= level_q + {1'b0, inflight} - {1'b0, xfer};
      end
   end

`ifdef FIFO_RD_CNT_EN
   // Count completed downstream transfers, wrapping at 16 bits.
   always_ff @(posedge rclk or negedge rrstn) begin
      if (!rrstn)    rd_cnt <= '0;
      else if (xfer) rd_cnt <= rd_cnt + 16'd1;
   end
`endif

   // Outputs come straight from registers; no bypass from rdata.
   always_comb begin
      out_valid = (level_q != 2'd0);
      out_data  = mem[rd_ptr];
      level     = level_q;
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: models the upstream FIFO (registered read port)
// and a scoreboard of popped words compared against the downstream stream.
// Define FIFO_RD_CNT_EN to also exercise the rd_cnt wrap.
module tb_fifo_rd_stream;

   logic       rclk;
   logic       rrstn;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] level;
`ifdef FIFO_RD_CNT_EN
   logic [15:0] rd_cnt;
`endif

   fifo_rd_stream #(.WIDTH(8)) dut (
      .rclk      (rclk),
      .rrstn     (rrstn),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_cnt    (rd_cnt)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] up_q [$];
   logic [7:0] sb   [$];
   int         lvl_m;
   int         inf_m;
   int         pops;
   int         xfer_m;
   logic [15:0] rinc_hist;
   logic [15:0] valid_hist;
   logic [7:0] first_xfer;
   logic       seen_xfer;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a falling edge; checks the cycle against the model,
   // then lets the upstream FIFO react to the pop at the rising edge.
   task automatic step(input logic rdy, input logic hold_empty);
      logic exp_rinc, exp_xfer, did_pop;
      out_ready = rdy;
      rempty    = hold_empty || (up_q.size() == 0);
      #1;
      exp_rinc = !rempty && ((lvl_m + inf_m) < 3);
      exp_xfer = (lvl_m != 0) && rdy;
      chk("rinc", 32'(rinc), 32'(exp_rinc));
      chk("out_valid", 32'(out_valid), 32'(lvl_m != 0));
      chk("level", 32'(level), 32'(lvl_m));
      if (lvl_m != 0) begin
         if (sb.size() > 0) chk("out_data", 32'(out_data), 32'(sb[0]));
         else               chk("sb_size", 32'(sb.size()), 32'd1);
      end
      if (exp_xfer && sb.size() > 0) begin
         if (!seen_xfer) first_xfer = sb[0];
         seen_xfer = 1'b1;
         void'(sb.pop_front());
         xfer_m++;
      end
      rinc_hist  = {rinc_hist[14:0], rinc};
      valid_hist = {valid_hist[14:0], out_valid};
      did_pop    = rinc && !rempty;
      @(posedge rclk);
      lvl_m = lvl_m + inf_m - int'(exp_xfer);
      inf_m = int'(exp_rinc);
      #1;
      if (did_pop) begin
         rdata = up_q.pop_front();
         sb.push_back(rdata);
         pops++;
      end
      @(negedge rclk);
   endtask

   // Called at a falling edge; asserts reset asynchronously mid-cycle.
   task automatic do_reset();
      rrstn  = 1'b0;
      rempty = 1'b0;
      #1;
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      up_q.delete();
      sb.delete();
      lvl_m = 0; inf_m = 0; pops = 0; xfer_m = 0;
      rinc_hist = '0; valid_hist = '0; seen_xfer = 1'b0; first_xfer = '0;
      @(posedge rclk);
      @(negedge rclk);
      rrstn = 1'b1;
   endtask

   initial begin
      rrstn = 1'b0; rempty = 1'b1; rdata = '0; out_ready = 1'b0;
      @(negedge rclk);

      // Straight stream, ready held high.
      do_reset();
      up_q.push_back(8'h11); up_q.push_back(8'h22);
      up_q.push_back(8'h33); up_q.push_back(8'h44);
      repeat (6) step(1'b1, 1'b0);
      chk("stream_rinc_pattern", 32'(rinc_hist[5:0]), 32'(6'b111100));
      chk("stream_valid_pattern", 32'(valid_hist[5:0]), 32'(6'b001111));
      chk("stream_xfers", 32'(xfer_m), 32'd4);
      chk("stream_first", 32'(first_xfer), 32'h11);
`ifdef FIFO_RD_CNT_EN
      chk("stream_rd_cnt", 32'(rd_cnt), 32'd4);
`endif

      // Backpressure: buffer fills to 3 and holds the first word.
      do_reset();
      for (int i = 1; i <= 10; i++) up_q.push_back(8'(i));
      repeat (8) step(1'b0, 1'b0);
      chk("bp_pops", 32'(pops), 32'd3);
      chk("bp_level", 32'(level), 32'd3);
      chk("bp_rinc", 32'(rinc), 32'd0);
      chk("bp_head", 32'(out_data), 32'h01);

      // Toggled ready from a full buffer, then drain.
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
      chk("toggle_pops", 32'(pops), 32'd5);
      chk("toggle_xfers", 32'(xfer_m), 32'd2);
      repeat (20) step(1'b1, 1'b0);
      chk("drain_xfers", 32'(xfer_m), 32'd10);
      chk("drain_level", 32'(level), 32'd0);

      // Single word, upstream empties right after the pop.
      do_reset();
      up_q.push_back(8'hA5);
      repeat (3) step(1'b0, 1'b0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_rinc", 32'(rinc), 32'd0);
      step(1'b1, 1'b0);
      chk("single_level", 32'(level), 32'd0);
      chk("single_valid_after", 32'(out_valid), 32'd0);

      // Reset while level=2 with a word in flight.
      do_reset();
      for (int i = 0; i < 6; i++) up_q.push_back(8'(8'h61 + i));
      repeat (3) step(1'b0, 1'b0);
      chk("mid_level", 32'(level), 32'd2);
      chk("mid_inflight_model", 32'(inf_m), 32'd1);
      do_reset();
      up_q.push_back(8'h5A);
      repeat (4) step(1'b1, 1'b0);
      chk("post_rst_first", 32'(first_xfer), 32'h5A);
      chk("post_rst_xfers", 32'(xfer_m), 32'd1);

`ifdef FIFO_RD_CNT_EN
      // Transfer counter wrap after 65537 transfers.
      do_reset();
      for (int i = 0; i < 70000 && xfer_m < 65537; i++) begin
         if (up_q.size() < 2) up_q.push_back(8'(i));
         step(1'b1, 1'b0);
      end
      chk("cnt_xfers", 32'(xfer_m), 32'd65537);
      chk("cnt_wrap", 32'(rd_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; must match the upstream FIFO's read data width.
REQ-002 SHALL have parameter BUF_DEPTH, fixed at 3, local skid-buffer entries; not overridable.
REQ-003 SHALL have port rclk  input  1  read-domain clock; all logic on the rising edge.
REQ-004 SHALL have port rrstn  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 SHALL have port rempty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port rdata  input  WIDTH  upstream FIFO read data.
REQ-007 SHALL have port rinc  output  1  pop request to upstream FIFO.
REQ-008 SHALL have port out_valid  output  1  downstream word available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts word.
REQ-010 SHALL have port out_data  output  WIDTH  downstream word, oldest buffered entry.
REQ-011 SHALL have port level  output  2  number of buffered entries, 0..3.

Function
REQ-012 SHALL treat the upstream FIFO read as registered: a pop in cycle N (rinc=1, rempty=0) presents the word on rdata from the rising edge ending cycle N until the next pop.
REQ-013 SHALL drive rinc = !rempty && (level + inflight < 3), combinationally from registers and rempty only; no path from out_ready to rinc.
REQ-014 SHALL set the internal inflight bit to 1 in the cycle after a pop and clear it otherwise; at most one word is in flight.
REQ-015 SHALL write rdata into the buffer tail in every cycle where inflight=1.
REQ-016 SHALL assert out_valid iff level != 0; out_data = head entry; both are driven from registers.
REQ-017 SHALL define a transfer as out_valid && out_ready; on a transfer the head advances by one.
REQ-018 SHALL handle a simultaneous capture and transfer in one cycle: level unchanged, FIFO order preserved; when level=0, the captured word appears on out_data in the next cycle, with no bypass.
REQ-019 SHALL never overflow: level+inflight never exceeds 3; pointers wrap modulo 3.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain one word per cycle from upstream non-empty to out_ready held high after a 2-cycle fill latency: pop in N, capture in N+1, out_valid in N+2.
REQ-022 SHALL ignore rdata when inflight=0; rempty rising mid-stream only stops new pops, and the in-flight word is still captured.

Reset
REQ-023 SHALL, while rrstn=0, force rinc=0, out_valid=0, out_data=0, level=0, inflight=0, and buffer pointers to 0.
REQ-024 SHALL discard an in-flight word if reset asserts mid-operation; the upstream FIFO read side is reset from the same rrstn.
REQ-025 SHALL release from reset on the first rising edge of rclk with rrstn=1, with the first pop possible in that cycle.

Configuration
REQ-026 SHALL, when macro FIFO_RD_CNT_EN is defined, add output rd_cnt  output  16  count of completed transfers, reset to 0, +1 per transfer, wrapping from 65535 to 0.
REQ-027 SHALL, when FIFO_RD_CNT_EN is undefined, omit rd_cnt entirely; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover this scenario: upstream holds 0x11,0x22,0x33,0x44 and out_ready=1 throughout -> pop in cycles 1-4, out_valid in cycles 3-6, out_data 0x11,0x22,0x33,0x44 in order, no gaps.
REQ-029 SHALL cover this scenario: out_ready=0, upstream holds 10 words -> exactly 3 pops, level=3, rinc=0 thereafter, out_data=first word held stable.
REQ-030 SHALL cover this scenario: from level=3, out_ready toggled 1,0,1,0 -> one transfer per high cycle, a new pop after each transfer, order preserved, and level never above 3.
REQ-031 SHALL cover this scenario: rempty rises the cycle after a single pop of 0xA5 -> 0xA5 is captured, out_valid=1, then rinc stays 0 and level returns to 0 after the transfer.
REQ-032 SHALL cover this scenario: rrstn pulsed low while level=2 and inflight=1 -> all outputs are 0 immediately (asynchronous), and after release a fresh word 0x5A is delivered first.
REQ-033 SHALL cover this scenario: with FIFO_RD_CNT_EN defined, 65537 transfers -> rd_cnt=1.
